mpsoc_noc_vchannel_demux_buffer: RTL

Receive-side counterpart of the virtual-channel link multiplexer. It takes one physical link carrying a shared flit/last bus, a one-hot per-channel valid and a per-channel ready. It steers each accepted flit into a per-channel FIFO and presents independent valid/ready streams per virtual channel to the router input stage. Per-channel ready is derived only from local buffer state, so no combinational path crosses the link.

---
 rtl/mpsoc_noc_pkg.sv | 16 +
 rtl/mpsoc_noc_vchannel_fifo.sv | 68 ++++++
 rtl/mpsoc_noc_vchannel_demux_buffer.sv | 45 ++++
 3 files changed

// File: rtl/mpsoc_noc_pkg.sv
// Shared NoC types and helpers for the virtual-channel link logic.
// Flit record layout and pointer-width helper used by the channel buffers.
package mpsoc_noc_pkg;

   localparam int FLIT_WIDTH_DEFAULT = 32;

   typedef struct packed {
      logic                          last;
      logic [FLIT_WIDTH_DEFAULT-1:0] flit;
   } flit_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mpsoc_noc_vchannel_fifo.sv
// Single virtual-channel FIFO: registered ready, occupancy count,
// first-word fall-through head.
module mpsoc_noc_vchannel_fifo
   import mpsoc_noc_pkg::*;
#(
   parameter int FLIT_WIDTH   = FLIT_WIDTH_DEFAULT,
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FLIT_WIDTH-1:0] in_flit,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [FLIT_WIDTH-1:0] out_flit,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int PW = ptr_width(BUFFER_DEPTH);
   localparam int CW = PW + 1;

   logic [FLIT_WIDTH:0] mem [BUFFER_DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic [CW-1:0]       count_next;
   logic                ready_q;
   logic                push;
   logic                pop;

   assign in_ready  = ready_q;
   assign out_valid = (count != '0);
   assign push      = in_valid & ready_q;
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_next = count;
      unique case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Ready looks one edge ahead so the link never sees a comb path.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count   <= count_next;
         ready_q <= (count_next < CW'(BUFFER_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_last, in_flit};
   end

   assign {out_last, out_flit} = mem[rd_ptr];

endmodule

// File: rtl/mpsoc_noc_vchannel_demux_buffer.sv
// Receive side of the VC link: steers the shared flit bus into
// independent per-channel FIFOs and gathers per-channel ready.
module mpsoc_noc_vchannel_demux_buffer
   import mpsoc_noc_pkg::*;
#(
   parameter int FLIT_WIDTH   = FLIT_WIDTH_DEFAULT,
   parameter int CHANNELS     = 7,
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [FLIT_WIDTH-1:0]               in_flit,
   input  logic                                in_last,
   input  logic [CHANNELS-1:0]                 in_valid,
   output logic [CHANNELS-1:0]                 in_ready,
   output logic [CHANNELS-1:0][FLIT_WIDTH-1:0] out_flit,
   output logic [CHANNELS-1:0]                 out_last,
   output logic [CHANNELS-1:0]                 out_valid,
   input  logic [CHANNELS-1:0]                 out_ready
);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      mpsoc_noc_vchannel_fifo #(
         .FLIT_WIDTH   (FLIT_WIDTH),
         .BUFFER_DEPTH (BUFFER_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .in_flit   (in_flit),
         .in_last   (in_last),
         .in_valid  (in_valid[c]),
         .in_ready  (in_ready[c]),
         .out_flit  (out_flit[c]),
         .out_last  (out_last[c]),
         .out_valid (out_valid[c]),
         .out_ready (out_ready[c])
      );
   end

   // The link drives at most one channel valid per cycle.
   a_valid_onehot : assert property (
      @(posedge clk) disable iff (!rst) $onehot0(in_valid)
   );

endmodule
